// File: rtl/seq_shift_add_multiplier.sv
// ============================================================================
// Module   : seq_shift_add_multiplier
// Brief    : Iterative shift-and-add multiplier, BITS_PER_CYCLE multiplier bits
//            per clock, unsigned or two's-complement operands, valid/ready I/O.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_shift_add_multiplier #(
  parameter int M_WIDTH        = 8,
  parameter int N_WIDTH        = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [M_WIDTH-1:0]         a,
  input  logic [N_WIDTH-1:0]         b,
  input  logic                       signed_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [M_WIDTH+N_WIDTH-1:0] product,
  output logic                       busy
);

  localparam int ITER    = N_WIDTH / BITS_PER_CYCLE;
  localparam int P_WIDTH = M_WIDTH + N_WIDTH;
  localparam int CNT_W   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [P_WIDTH-1:0] r_a_sh;
  logic [N_WIDTH-1:0] r_b_sh;
  logic [P_WIDTH-1:0] r_acc;
  logic [P_WIDTH-1:0] r_product;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  logic [M_WIDTH-1:0] w_a_mag;
  logic [N_WIDTH-1:0] w_b_mag;
  logic               w_neg;
  logic [P_WIDTH-1:0] w_step;
  logic [P_WIDTH-1:0] w_acc_next;

  // -2^(W-1) negates to itself, which read unsigned is the correct magnitude
  always_comb begin
    w_a_mag = (signed_mode && a[M_WIDTH-1]) ? -a : a;
    w_b_mag = (signed_mode && b[N_WIDTH-1]) ? -b : b;
    w_neg   = signed_mode & (a[M_WIDTH-1] ^ b[N_WIDTH-1]);
  end

  // Multiplicand is pre-shifted and multiplier consumed from the LSB end
  always_comb begin
    w_step = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (r_b_sh[j]) begin
        w_step = w_step + (r_a_sh << j);
      end
    end
    w_acc_next = r_acc + w_step;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_acc       <= '0;
      r_product   <= '0;
      r_cnt       <= '0;
      r_neg       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_sh     <= P_WIDTH'(w_a_mag);
            r_b_sh     <= w_b_mag;
            r_neg      <= w_neg;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc  <= w_acc_next;
          r_a_sh <= r_a_sh << BITS_PER_CYCLE;
          r_b_sh <= r_b_sh >> BITS_PER_CYCLE;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == c_last_iter) begin
            r_product   <= r_neg ? -w_acc_next : w_acc_next;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign product   = r_product;
  assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_add_multiplier.sv
// ============================================================================
// Module   : tb_seq_shift_add_multiplier
// Brief    : Self-checking bench for seq_shift_add_multiplier (BPC=1 and BPC=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_shift_add_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        iv1 = 1'b0, ir1, sm1 = 1'b0, ov1, or1 = 1'b1, bz1;
  logic [7:0]  a1 = '0, b1 = '0;
  logic [15:0] p1;
  logic        iv2 = 1'b0, ir2, sm2 = 1'b0, ov2, or2 = 1'b1, bz2;
  logic [7:0]  a2 = '0, b2 = '0;
  logic [15:0] p2;

  int n_tests = 0;
  int n_fail  = 0;

  seq_shift_add_multiplier #(.M_WIDTH(8), .N_WIDTH(8), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .signed_mode(sm1), .out_valid(ov1), .out_ready(or1), .product(p1), .busy(bz1)
  );

  seq_shift_add_multiplier #(.M_WIDTH(8), .N_WIDTH(8), .BITS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .signed_mode(sm2), .out_valid(ov2), .out_ready(or2), .product(p2), .busy(bz2)
  );

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y,
                                          input logic s);
    longint px, py;
    px = s ? longint'($signed(x)) : longint'(x);
    py = s ? longint'($signed(y)) : longint'(y);
    return 16'(px * py);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [7:0] x,
                       input logic [7:0] y, input logic s);
    if (d == 1) begin iv1 = v; a1 = x; b1 = y; sm1 = s; end
    else        begin iv2 = v; a2 = x; b2 = y; sm2 = s; end
  endtask

  function automatic logic rdy(input int d);  return (d == 1) ? ir1 : ir2; endfunction
  function automatic logic vld(input int d);  return (d == 1) ? ov1 : ov2; endfunction
  function automatic logic bsy(input int d);  return (d == 1) ? bz1 : bz2; endfunction
  function automatic logic [15:0] prd(input int d); return (d == 1) ? p1 : p2; endfunction

  // One operation: accept, then count edges until out_valid
  task automatic do_op(input int d, input logic [7:0] x, input logic [7:0] y,
                       input logic s, input int lat, input logic [15:0] exp);
    int n;
    @(negedge clk);
    check("in_ready_idle", 32'(rdy(d)), 32'd1);
    drive(d, 1'b1, x, y, s);
    @(posedge clk); #1;
    drive(d, 1'b0, x, y, s);
    check("busy_calc", 32'(bsy(d)), 32'd1);
    n = 0;
    while (!vld(d) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(lat));
    check("product", 32'(prd(d)), 32'(exp));
  endtask

  task automatic release_op(input int d);
    @(posedge clk); #1;
    check("out_valid_drop", 32'(vld(d)), 32'd0);
    check("in_ready_back", 32'(rdy(d)), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  ra, rb;
    logic        rs;
    logic [15:0] q[$];
    logic [15:0] held;
    int          last, cyc, idx, got;
    logic        take;
    logic [7:0]  opa[4], opb[4];
    logic        ops[4];

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(ov1), 32'd0);
    check("rst_product", 32'(p1), 32'd0);
    check("rst_in_ready", 32'(ir1), 32'd1);
    check("rst_busy", 32'(bz1), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Directed unsigned and signed, BPC=1
    do_op(1, 8'd255, 8'd255, 1'b0, 8, 16'hFE01); release_op(1);
    do_op(1, 8'h80, 8'h80, 1'b1, 8, 16'h4000);  release_op(1);
    do_op(1, 8'hFF, 8'd127, 1'b1, 8, 16'hFF81); release_op(1);
    do_op(1, 8'd0, 8'hFB, 1'b1, 8, 16'h0000);   release_op(1);
    do_op(1, 8'h80, 8'h80, 1'b0, 8, 16'h4000);  release_op(1);

    // BPC=2
    do_op(2, 8'd200, 8'd3, 1'b0, 4, 16'h0258);  release_op(2);
    do_op(2, 8'h80, 8'h7F, 1'b1, 4, 16'hC080);  release_op(2);

    // Backpressure in DONE; a=1,b=1 offered meanwhile must be ignored
    or1 = 1'b0;
    do_op(1, 8'd13, 8'd11, 1'b0, 8, 16'd143);
    held = p1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1, 1'b1, 8'd1, 8'd1, 1'b0);
      @(posedge clk); #1;
      check("bp_out_valid", 32'(ov1), 32'd1);
      check("bp_product", 32'(p1), 32'(held));
      check("bp_in_ready", 32'(ir1), 32'd0);
    end
    @(negedge clk);
    drive(1, 1'b0, 8'd0, 8'd0, 1'b0);
    or1 = 1'b1;
    release_op(1);
    do_op(1, 8'd3, 8'd5, 1'b0, 8, 16'd15); release_op(1);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    drive(1, 1'b1, 8'd100, 8'd100, 1'b0);
    @(posedge clk); #1;
    drive(1, 1'b0, 8'd0, 8'd0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(ov1), 32'd0);
    check("arst_product", 32'(p1), 32'd0);
    check("arst_in_ready", 32'(ir1), 32'd1);
    check("arst_busy", 32'(bz1), 32'd0);
    @(negedge clk); rst = 1'b0;
    do_op(1, 8'd7, 8'd6, 1'b0, 8, 16'd42); release_op(1);

    // Random sweep: 1000 pairs on BPC=2, 100 on BPC=1
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom_range(0, 1));
      do_op(2, ra, rb, rs, 4, ref_mul(ra, rb, rs)); release_op(2);
    end
    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom_range(0, 1));
      do_op(1, ra, rb, rs, 8, ref_mul(ra, rb, rs)); release_op(1);
    end

    // Back-to-back, in_valid held high: one IDLE, ITER CALC and one DONE cycle per op
    for (int i = 0; i < 4; i++) begin
      opa[i] = 8'($urandom); opb[i] = 8'($urandom); ops[i] = 1'($urandom_range(0, 1));
    end
    last = -1; cyc = 0; idx = 0; got = 0;
    while (got < 4 && cyc < 100) begin
      @(negedge clk);
      take = ir1 && (idx < 4);
      if (idx < 4) drive(1, 1'b1, opa[idx], opb[idx], ops[idx]);
      else         drive(1, 1'b0, 8'd0, 8'd0, 1'b0);
      @(posedge clk); #1;
      if (take) begin
        if (last >= 0) check("b2b_spacing", 32'(cyc - last), 32'd10);
        last = cyc;
        q.push_back(ref_mul(opa[idx], opb[idx], ops[idx]));
        idx++;
      end
      if (ov1) begin
        if (q.size() == 0) check("b2b_unexpected", 32'd1, 32'd0);
        else check("b2b_product", 32'(p1), 32'(q.pop_front()));
        got++;
      end
      cyc++;
    end
    drive(1, 1'b0, 8'd0, 8'd0, 1'b0);
    check("b2b_count", 32'(got), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
